// File: rtl/alu_issue.sv
// alu_issue: issues one decoded MIPS ALU instruction at a time to an external 32-bit ALU.
// It holds the ALU inputs for EXEC_CYCLES clock edges, captures the ALU result and then
// returns that result together with the destination register index.
//
// Ports
//   clk, reset_n                 clock; asynchronous active-low reset
//   in_valid/in_ready            instruction handshake; in_ready is high only while idle
//   in_instr, in_rs, in_rt       instruction word and the two register operands
//   alu_a, alu_b, alu_op         registered drive to the external ALU
//   alu_c                        result returned by the external ALU
//   out_valid/out_ready          result handshake
//   out_data, out_rd, out_err    result value, destination index, unsupported-instruction flag
module alu_issue #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] LastCnt = 4'(EXEC_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q;

  // Instruction fields
  logic [5:0]  opc, funct;
  logic [4:0]  sh;
  logic [15:0] imm;
  assign opc   = in_instr[31:26];
  assign funct = in_instr[5:0];
  assign sh    = in_instr[10:6];
  assign imm   = in_instr[15:0];

  // The rs field is not needed: the operand value arrives on in_rs.
  logic unused_rs_field;
  assign unused_rs_field = ^in_instr[25:21];

  // Decoded operation for the instruction currently on in_*
  logic        dec_legal;
  logic [31:0] dec_a, dec_b;
  logic [2:0]  dec_op;
  logic [4:0]  dec_rd;

  always_comb begin
    dec_legal = 1'b0;
    dec_a     = in_rs;
    dec_b     = in_rt;
    dec_op    = 3'd0;
    dec_rd    = in_instr[20:16];
    case (opc)
      6'h00: begin
        dec_rd = in_instr[15:11];
        case (funct)
          6'h21: begin dec_legal = 1'b1; dec_op = 3'd0; end
          6'h23: begin dec_legal = 1'b1; dec_op = 3'd1; end
          6'h24: begin dec_legal = 1'b1; dec_op = 3'd2; end
          6'h25: begin dec_legal = 1'b1; dec_op = 3'd3; end
          6'h02, 6'h03: begin
            dec_legal = 1'b1;
            dec_a     = in_rt;
            dec_b     = {27'b0, sh};
            dec_op    = funct[0] ? 3'd5 : 3'd4;
          end
          // Variable shifts: the ALU shifts by the full B, so mask the amount to 5 bits here.
          6'h06, 6'h07: begin
            dec_legal = 1'b1;
            dec_a     = in_rt;
            dec_b     = {27'b0, in_rs[4:0]};
            dec_op    = funct[0] ? 3'd5 : 3'd4;
          end
          default: ;
        endcase
      end
      6'h09: begin dec_legal = 1'b1; dec_b = {{16{imm[15]}}, imm}; dec_op = 3'd0; end
      6'h0C: begin dec_legal = 1'b1; dec_b = {16'b0, imm};         dec_op = 3'd2; end
      6'h0D: begin dec_legal = 1'b1; dec_b = {16'b0, imm};         dec_op = 3'd3; end
      6'h0F: begin dec_legal = 1'b1; dec_a = 32'b0; dec_b = {imm, 16'b0}; dec_op = 3'd0; end
      default: ;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (in_valid) state_d = dec_legal ? StExec : StDone;
      StExec: if (cnt_q == LastCnt) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      alu_a    <= 32'b0;
      alu_b    <= 32'b0;
      alu_op   <= 3'd0;
      out_data <= 32'b0;
      out_rd   <= 5'd0;
      out_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            cnt_q <= 4'd0;
            if (dec_legal) begin
              alu_a   <= dec_a;
              alu_b   <= dec_b;
              alu_op  <= dec_op;
              out_rd  <= dec_rd;
              out_err <= 1'b0;
            end else begin
              // Unsupported: skip the ALU entirely, leaving its inputs untouched.
              out_rd   <= 5'd0;
              out_err  <= 1'b1;
              out_data <= 32'b0;
            end
          end
        end
        StExec: begin
          if (cnt_q == LastCnt) out_data <= alu_c;
          else                  cnt_q    <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
